// File: rtl/display_frame_pkg.sv
// Shared frame-format definitions for the display stream receive path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package display_frame_pkg;

    // Slot tracker states: HUNT waits for sync, Sx expects slot x next.
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        S0   = 2'd1,
        S1   = 2'd2,
        S2   = 2'd3
    } slot_state_t;

    // Reserved bits that must be zero in each slot byte.
    localparam logic [7:0] SLOT0_RSVD_MASK = 8'hC3;
    localparam logic [7:0] SLOT1_RSVD_MASK = 8'hC3;
    localparam logic [7:0] SLOT2_RSVD_MASK = 8'hE0;

    // Field positions inside the slot bytes.
    localparam int JOHNSON_LSB = 2;
    localparam int HOURS_LSB   = 2;
    localparam int MINUTES_LSB = 1;
    localparam int DP_BIT      = 0;

    // One bit per 4-bit code; set for the eight legal Johnson states
    // 0000,1000,1100,1110,1111,0111,0011,0001.
    localparam logic [15:0] JOHNSON_VALID = 16'hD18B;

    function automatic logic johnson_ok(input logic [3:0] code);
        return JOHNSON_VALID[code];
    endfunction

    // Hex digit to active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Hex nibble to 7-segment pattern, polarity selectable.
// Latency: combinational.
// Backpressure: none.
module seg7_encoder
    import display_frame_pkg::*;
#(
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Invert the active-high table when the board drives segments low-true.
    assign seg = SEG_ACT_LOW ? ~hex_to_seg(hex) : hex_to_seg(hex);

endmodule

// File: rtl/display_stream_decoder.sv
// Aligns the 3-slot display byte stream, validates frames, commits them to 7-seg outputs.
// Latency: 1 cycle from accepted slot2 byte to committed outputs / pulse.
// Backpressure: none; in_valid=0 stalls the tracker with all state held.
module display_stream_decoder
    import display_frame_pkg::*;
#(
    parameter int LOCK_FRAMES = 2,
    parameter int UNLOCK_ERRS = 2,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] display_in,
    input  logic       in_valid,
    input  logic       sync,
    output logic [3:0] johnson_q,
    output logic [3:0] hours_q,
    output logic [3:0] minutes_q,
    output logic       dp_q,
    output logic [6:0] seg_hours,
    output logic [6:0] seg_minutes,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       locked
);

    localparam logic [4:0] LOCK_TH   = 5'(LOCK_FRAMES);
    localparam logic [4:0] UNLOCK_TH = 5'(UNLOCK_ERRS);

    slot_state_t state_q, state_d;
    logic [3:0]  johnson_sh, hours_sh;
    logic        err_sh;
    logic [3:0]  good_cnt, bad_cnt;

    logic slot0_err, slot1_err, slot2_err;
    logic take_slot0, take_slot1, frame_good, frame_bad, unlock;

    assign slot0_err = (|(display_in & SLOT0_RSVD_MASK))
                     | ~johnson_ok(display_in[JOHNSON_LSB +: 4]);
    assign slot1_err = |(display_in & SLOT1_RSVD_MASK);
    assign slot2_err = |(display_in & SLOT2_RSVD_MASK);

    // Bad frame that reaches the threshold forces a fresh sync hunt.
    assign unlock = frame_bad && (({1'b0, bad_cnt} + 5'd1) >= UNLOCK_TH);

    // Slot state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= HUNT;
        else     state_q <= state_d;
    end

    // Next slot: unlock beats everything, else follow the accepted byte.
    always_comb begin
        state_d = state_q;
        if (unlock)                       state_d = HUNT;
        else if (take_slot0)              state_d = S1;
        else if (take_slot1)              state_d = S2;
        else if (frame_good || frame_bad) state_d = S0;
    end

    // Per-byte actions; a sync in S1/S2 aborts the frame and restarts at slot0.
    always_comb begin
        take_slot0 = 1'b0;
        take_slot1 = 1'b0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: take_slot0 = sync;
                S0:   take_slot0 = 1'b1;
                S1: begin
                    if (sync) begin
                        frame_bad  = 1'b1;
                        take_slot0 = 1'b1;
                    end else begin
                        take_slot1 = 1'b1;
                    end
                end
                default: begin
                    if (sync) begin
                        frame_bad  = 1'b1;
                        take_slot0 = 1'b1;
                    end else if (err_sh || slot2_err) begin
                        frame_bad  = 1'b1;
                    end else begin
                        frame_good = 1'b1;
                    end
                end
            endcase
        end
    end

    // Shadow capture of slot0/slot1 fields with an error flag sticky per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            johnson_sh <= '0;
            hours_sh   <= '0;
            err_sh     <= 1'b0;
        end else if (take_slot0) begin
            johnson_sh <= display_in[JOHNSON_LSB +: 4];
            err_sh     <= slot0_err;
        end else if (take_slot1) begin
            hours_sh   <= display_in[HOURS_LSB +: 4];
            err_sh     <= err_sh | slot1_err;
        end
    end

    // Commit a whole good frame; pulses last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            johnson_q   <= '0;
            hours_q     <= '0;
            minutes_q   <= '0;
            dp_q        <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_good;
            frame_err   <= frame_bad;
            if (frame_good) begin
                johnson_q <= johnson_sh;
                hours_q   <= hours_sh;
                minutes_q <= display_in[MINUTES_LSB +: 4];
                dp_q      <= display_in[DP_BIT];
            end
        end
    end

    // Lock hysteresis: consecutive good frames raise it, consecutive bad frames drop it.
    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
        end else if (frame_good) begin
            bad_cnt <= '0;
            if (({1'b0, good_cnt} + 5'd1) >= LOCK_TH) begin
                good_cnt <= LOCK_TH[3:0];
                locked   <= 1'b1;
            end else begin
                good_cnt <= good_cnt + 4'd1;
            end
        end else if (frame_bad) begin
            good_cnt <= '0;
            if (unlock) begin
                bad_cnt <= '0;
                locked  <= 1'b0;
            end else if (bad_cnt != 4'hF) begin
                bad_cnt <= bad_cnt + 4'd1;
            end
        end
    end

    seg7_encoder #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_seg_hours (
        .hex (hours_q),
        .seg (seg_hours)
    );

    seg7_encoder #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_seg_minutes (
        .hex (minutes_q),
        .seg (seg_minutes)
    );

endmodule
